teknofest_ram_loader: RTL and testbench
=======================================

Name: teknofest_ram_loader

Overview:
Parametrised successor to the on-chip RAM programmer. Takes a byte stream from an external UART receiver with a valid/byte interface and matches a parametrised magic sequence. Then loads a base address, a word count and NB_COL*COL_WIDTH-bit data words into the RAM write port. Sits between the core's RAM write port and the RAM. Owns write-port arbitration and the post-load core reset pulse.

Parameters:
NB_COL, 4, byte-lane columns per RAM word
COL_WIDTH, 8, bits per column; NB_COL*COL_WIDTH must be a multiple of 8 (BPW = NB_COL*COL_WIDTH/8 bytes per word)
ADDR_W, 17, RAM word-address width
MAGIC, "TEKNOFEST", unlock sequence, first character sent first
MAGIC_LEN, 9, length of MAGIC in bytes (1..16)
TIMEOUT_CYC, 1000000, idle cycles between bytes before abort
RST_PULSE_CYC, 16, length of system reset pulse in cycles (>=1)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
rx_byte_i  in  8  received UART byte
rx_valid_i  in  1  one-cycle strobe, rx_byte_i valid
core_wr_addr_i  in  ADDR_W  core write address
core_wr_data_i  in  NB_COL*COL_WIDTH  core write data
core_wr_strb_i  in  NB_COL  core byte-lane strobes
ram_wr_addr_o  out  ADDR_W  merged RAM write address
ram_wr_data_o  out  NB_COL*COL_WIDTH  merged RAM write data
ram_wr_strb_o  out  NB_COL  merged RAM strobes
system_reset_no  out  1  active-low core reset
prog_mode_o  out  1  loader owns RAM write port
prog_done_o  out  1  one-cycle pulse, load completed
prog_err_o  out  1  one-cycle pulse, load aborted

Behaviour:
- Reset values: state IDLE, system_reset_no=1, prog_mode_o=0, prog_done_o=0, prog_err_o=0, internal write strobe 0, all counters 0.
- States: IDLE, MAGIC, BASE, COUNT, DATA, CHECK (optional feature only), RESET.
- IDLE: on rx_valid_i with byte==MAGIC[0], go to MAGIC with index=1. Any other byte is ignored. If MAGIC_LEN==1, go straight to BASE.
- MAGIC: each valid byte is compared with MAGIC[index].
  - Match and index==MAGIC_LEN-1: go to BASE.
  - Match otherwise: index+1.
  - Mismatch with byte==MAGIC[0]: index=1, stay in MAGIC.
  - Any other mismatch: go to IDLE. No error pulse.
- BASE: collect 4 bytes MSB first into the word address. Truncate to ADDR_W. Then go to COUNT.
- COUNT: collect 4 bytes MSB first into the 32-bit word count.
  - Count==0: go to CHECK, or to RESET without the feature.
  - Otherwise: go to DATA.
- DATA: collect BPW bytes MSB first per word. On the last byte, the next cycle drives one write:
  - ram_wr_addr_o=current address, ram_wr_data_o=word, ram_wr_strb_o all ones, for exactly 1 cycle.
  - Address increments modulo 2^ADDR_W, so it wraps silently.
  - Word counter decrements; on reaching 0, go to CHECK, or RESET without the feature.
- Byte counters reset to 0 on every state entry.
- prog_mode_o=1 in BASE, COUNT, DATA and CHECK.
  - While set, core strobes are forced to 0 and core writes are dropped, not queued.
  - While clear, ram_wr_* is a combinational passthrough of core_wr_*.
  - The final loader write still completes on the cycle after the last byte, even when the state has already moved to RESET or CHECK.
- Timeout: a counter clears on every rx_valid_i and on state entry, and counts cycles in MAGIC..CHECK. Reaching TIMEOUT_CYC sends the FSM to IDLE and pulses prog_err_o. In MAGIC the return to IDLE happens without an error pulse.
- RESET:
  - prog_done_o pulses on entry.
  - system_reset_no=0 for exactly RST_PULSE_CYC cycles, then the FSM returns to IDLE with system_reset_no=1.
  - Bytes are ignored in this state.
- rst_ni assertion mid-load aborts immediately. Partial RAM contents stay; no write is issued.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: an 8-bit running sum covers all DATA bytes and clears on entry to BASE. CHECK waits for one byte.
  - (sum+byte) mod 256 == 0: go to RESET.
  - Otherwise: pulse prog_err_o, go to IDLE, system_reset_no stays 1.
- Not defined: no CHECK state; the last DATA word, or count==0, goes directly to RESET.

Test Plan:
- Send "TEKNOFEST", base 00000010, count 00000002, words DEADBEEF 01234567 -> writes at 0x10 and 0x11 with strb 4'hF. prog_done_o pulses; system_reset_no is low for 16 cycles.
- Send "TEKTEKNOFEST" then a valid header -> restart on 'T' works and the load proceeds. Send "TEKX" -> IDLE, no prog_err_o.
- Base 0001FFFF (ADDR_W=17), count 2 -> writes at 0x1FFFF then 0x00000.
- Stop after 2 data bytes with TIMEOUT_CYC=100 -> prog_err_o after 100 idle cycles, FSM in IDLE, no write, system_reset_no=1.
- Core strobe 4'h3 during DATA -> ram_wr_strb_o=0 except on loader write cycles. In IDLE -> passthrough with the same address and data.
- With LOADER_CHECKSUM_EN: data 01 02 03 04, checksum F6 -> RESET. Checksum F7 -> prog_err_o and no reset pulse.

Source files
------------

// File: rtl/teknofest_ram_loader.sv
// teknofest_ram_loader: UART-driven RAM programmer with write-port arbitration.
// Watches a received byte stream for the MAGIC unlock sequence, then takes a
// 4-byte base word address, a 4-byte word count and count*BPW data bytes
// (all MSB first). It writes each word into the RAM write port and finally
// holds the core in reset for RST_PULSE_CYC cycles.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing 8-bit checksum byte).
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   rx_byte_i/rx_valid_i received UART byte and its one-cycle strobe
//   core_wr_*_i          core RAM write port (addr, data, byte strobes)
//   ram_wr_*_o           merged RAM write port (core passthrough or loader)
//   system_reset_no      active-low core reset, pulsed after a good load
//   prog_mode_o          loader owns the RAM write port
//   prog_done_o          one-cycle pulse, load completed
//   prog_err_o           one-cycle pulse, load aborted
module teknofest_ram_loader #(
  parameter int unsigned NB_COL        = 4,
  parameter int unsigned COL_WIDTH     = 8,
  parameter int unsigned ADDR_W        = 17,
  parameter int unsigned MAGIC_LEN     = 9,
  parameter logic [8*MAGIC_LEN-1:0] MAGIC = "TEKNOFEST",
  parameter int unsigned TIMEOUT_CYC   = 1000000,
  parameter int unsigned RST_PULSE_CYC = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [7:0]                    rx_byte_i,
  input  logic                          rx_valid_i,
  input  logic [ADDR_W-1:0]             core_wr_addr_i,
  input  logic [NB_COL*COL_WIDTH-1:0]   core_wr_data_i,
  input  logic [NB_COL-1:0]             core_wr_strb_i,
  output logic [ADDR_W-1:0]             ram_wr_addr_o,
  output logic [NB_COL*COL_WIDTH-1:0]   ram_wr_data_o,
  output logic [NB_COL-1:0]             ram_wr_strb_o,
  output logic                          system_reset_no,
  output logic                          prog_mode_o,
  output logic                          prog_done_o,
  output logic                          prog_err_o
);

  localparam int unsigned DW    = NB_COL * COL_WIDTH;
  localparam int unsigned BPW   = DW / 8;
  localparam int unsigned BC_W  = $clog2(BPW) + 2;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RST_W = $clog2(RST_PULSE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAGIC,
    S_BASE,
    S_COUNT,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_RESET
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    magic_idx_q;
  logic [BC_W-1:0]     byte_cnt_q;
  logic [23:0]         shift_q;
  logic [DW-1:0]       word_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         count_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [RST_W-1:0]    rst_cnt_q;
  logic                wr_pend_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DW-1:0]       wr_data_q;
  logic                sys_rst_n_q;
  logic                prog_mode_q;
  logic                prog_done_q;
  logic                prog_err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum_q;
`endif

  // MAGIC is stored first-character-in-the-MSBs, as a string literal packs.
  function automatic logic [7:0] magic_at(input int unsigned i);
    return MAGIC[8*(MAGIC_LEN-1-i) +: 8];
  endfunction

  logic [7:0]    magic_cur;
  logic [7:0]    magic_first;
  logic [31:0]   field_nxt;
  logic [DW-1:0] word_nxt;
  logic          active;

  assign magic_cur   = magic_at(32'(magic_idx_q));
  assign magic_first = magic_at(0);
  assign field_nxt   = {shift_q, rx_byte_i};
  assign word_nxt    = DW'({word_q, rx_byte_i});
  assign active      = (state_q != S_IDLE) && (state_q != S_RESET);

  // Loader FSM with registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      magic_idx_q <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      rst_cnt_q   <= '0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      sys_rst_n_q <= 1'b1;
      prog_mode_q <= 1'b0;
      prog_done_q <= 1'b0;
      prog_err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      prog_done_q <= 1'b0;
      prog_err_q  <= 1'b0;
      wr_pend_q   <= 1'b0;

      // Idle-cycle counter; every state change happens on a byte, a timeout
      // or in RESET, so clearing on those covers clearing on state entry.
      if (rx_valid_i || !active) tmo_q <= '0;
      else                       tmo_q <= tmo_q + TMO_W'(1);

      if (active && !rx_valid_i && (tmo_q == TMO_W'(TIMEOUT_CYC - 1))) begin
        // A stalled unlock attempt is not an error; a stalled load is.
        state_q     <= S_IDLE;
        prog_mode_q <= 1'b0;
        byte_cnt_q  <= '0;
        magic_idx_q <= '0;
        prog_err_q  <= (state_q != S_MAGIC);
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rx_valid_i && (rx_byte_i == magic_first)) begin
              byte_cnt_q <= '0;
              if (MAGIC_LEN == 1) begin
                state_q     <= S_BASE;
                prog_mode_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                sum_q       <= '0;
`endif
              end else begin
                state_q     <= S_MAGIC;
                magic_idx_q <= IDX_W'(1);
              end
            end
          end

          S_MAGIC: begin
            if (rx_valid_i) begin
              if (rx_byte_i == magic_cur) begin
                if (magic_idx_q == IDX_W'(MAGIC_LEN - 1)) begin
                  state_q     <= S_BASE;
                  prog_mode_q <= 1'b1;
                  byte_cnt_q  <= '0;
                  magic_idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                  sum_q       <= '0;
`endif
                end else begin
                  magic_idx_q <= magic_idx_q + IDX_W'(1);
                end
              end else if (rx_byte_i == magic_first) begin
                // Mismatching byte may itself start a fresh sequence.
                magic_idx_q <= IDX_W'(1);
              end else begin
                state_q     <= S_IDLE;
                magic_idx_q <= '0;
              end
            end
          end

          S_BASE: begin
            if (rx_valid_i) begin
              shift_q    <= field_nxt[23:0];
              byte_cnt_q <= byte_cnt_q + BC_W'(1);
              if (byte_cnt_q == BC_W'(3)) begin
                addr_q     <= ADDR_W'(field_nxt);
                byte_cnt_q <= '0;
                state_q    <= S_COUNT;
              end
            end
          end

          S_COUNT: begin
            if (rx_valid_i) begin
              shift_q    <= field_nxt[23:0];
              byte_cnt_q <= byte_cnt_q + BC_W'(1);
              if (byte_cnt_q == BC_W'(3)) begin
                count_q    <= field_nxt;
                byte_cnt_q <= '0;
                if (field_nxt != 32'd0) begin
                  state_q <= S_DATA;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                  state_q     <= S_CHECK;
`else
                  state_q     <= S_RESET;
                  prog_mode_q <= 1'b0;
                  prog_done_q <= 1'b1;
                  sys_rst_n_q <= 1'b0;
`endif
                end
              end
            end
          end

          S_DATA: begin
            if (rx_valid_i) begin
              word_q     <= word_nxt;
              byte_cnt_q <= byte_cnt_q + BC_W'(1);
`ifdef LOADER_CHECKSUM_EN
              sum_q      <= sum_q + rx_byte_i;
`endif
              if (byte_cnt_q == BC_W'(BPW - 1)) begin
                // Word complete: the write is issued on the following cycle.
                byte_cnt_q <= '0;
                wr_pend_q  <= 1'b1;
                wr_addr_q  <= addr_q;
                wr_data_q  <= word_nxt;
                addr_q     <= addr_q + ADDR_W'(1);
                count_q    <= count_q - 32'd1;
                if (count_q == 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
                  state_q     <= S_CHECK;
`else
                  state_q     <= S_RESET;
                  prog_mode_q <= 1'b0;
                  prog_done_q <= 1'b1;
                  sys_rst_n_q <= 1'b0;
`endif
                end
              end
            end
          end

`ifdef LOADER_CHECKSUM_EN
          S_CHECK: begin
            if (rx_valid_i) begin
              prog_mode_q <= 1'b0;
              if (8'(sum_q + rx_byte_i) == 8'd0) begin
                state_q     <= S_RESET;
                prog_done_q <= 1'b1;
                sys_rst_n_q <= 1'b0;
              end else begin
                state_q    <= S_IDLE;
                prog_err_q <= 1'b1;
              end
            end
          end
`endif

          S_RESET: begin
            if (rst_cnt_q == RST_W'(RST_PULSE_CYC - 1)) begin
              state_q     <= S_IDLE;
              sys_rst_n_q <= 1'b1;
              rst_cnt_q   <= '0;
            end else begin
              rst_cnt_q <= rst_cnt_q + RST_W'(1);
            end
          end

          default: begin
            state_q     <= S_IDLE;
            prog_mode_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Write-port merge: a pending loader write always wins, even after the
  // FSM has left the programming states.
  always_comb begin
    ram_wr_addr_o = core_wr_addr_i;
    ram_wr_data_o = core_wr_data_i;
    ram_wr_strb_o = core_wr_strb_i;
    if (wr_pend_q) begin
      ram_wr_addr_o = wr_addr_q;
      ram_wr_data_o = wr_data_q;
      ram_wr_strb_o = '1;
    end else if (prog_mode_q) begin
      ram_wr_strb_o = '0;
    end
  end

  assign system_reset_no = sys_rst_n_q;
  assign prog_mode_o     = prog_mode_q;
  assign prog_done_o     = prog_done_q;
  assign prog_err_o      = prog_err_q;

endmodule

// File: tb/tb_teknofest_ram_loader.sv
module tb_teknofest_ram_loader;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned TMO    = 100;
  localparam int unsigned RSTP   = 16;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [16:0] core_addr;
  logic [31:0] core_data;
  logic [3:0]  core_strb;
  logic [16:0] ram_addr;
  logic [31:0] ram_data;
  logic [3:0]  ram_strb;
  logic        sys_rst_n;
  logic        prog_mode;
  logic        prog_done;
  logic        prog_err;

  teknofest_ram_loader #(
    .NB_COL(4), .COL_WIDTH(8), .ADDR_W(ADDR_W), .MAGIC_LEN(9),
    .MAGIC("TEKNOFEST"), .TIMEOUT_CYC(TMO), .RST_PULSE_CYC(RSTP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_byte_i(rx_byte), .rx_valid_i(rx_valid),
    .core_wr_addr_i(core_addr), .core_wr_data_i(core_data), .core_wr_strb_i(core_strb),
    .ram_wr_addr_o(ram_addr), .ram_wr_data_o(ram_data), .ram_wr_strb_o(ram_strb),
    .system_reset_no(sys_rst_n), .prog_mode_o(prog_mode),
    .prog_done_o(prog_done), .prog_err_o(prog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] words[$];
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          rstlow_cnt = 0;

  // Observe the RAM port and status pulses away from the active edge.
  always @(negedge clk) begin
    if (ram_strb != 4'h0) wq.push_back('{a: ram_addr, d: ram_data, s: ram_strb});
    if (prog_done) done_cnt++;
    if (prog_err) err_cnt++;
    if (!sys_rst_n) rstlow_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic send_w32(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[8*i +: 8]);
      idle(int'($urandom_range(0, 2)));
    end
  endtask

  // Full load of the words queue; delta!=0 corrupts the checksum byte.
  task automatic do_load(input logic [31:0] base, input logic [7:0] delta,
                         input bit noise, input string tag);
    int          n;
    int          d0;
    int          e0;
    int          r0;
    logic [7:0]  sum;
    bit          ok;
    wr_t         w;
    logic [7:0]  b;
    n   = words.size();
    d0  = done_cnt;
    e0  = err_cnt;
    r0  = rstlow_cnt;
    sum = 8'h00;
`ifdef LOADER_CHECKSUM_EN
    ok  = (delta == 8'h00);
`else
    ok  = 1'b1;
`endif
    wq.delete();
    send_str("TEKNOFEST");
    if (noise) begin
      core_addr = 17'($urandom);
      core_data = $urandom;
      core_strb = 4'h3;
    end
    send_w32(base);
    send_w32(32'(n));
    if (n != 0) begin
      chk({tag, "_mode"}, 64'(prog_mode), 64'(1));
      if (noise) chk({tag, "_strb_blk"}, 64'(ram_strb), 64'(0));
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 3; k >= 0; k--) begin
        b   = words[i][8*k +: 8];
        sum = sum + b;
        send_byte(b);
        if (i == n - 1 && k == 0) core_strb = 4'h0;
        else idle(int'($urandom_range(0, 2)));
      end
    end
    core_strb = 4'h0;
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'(8'h00 - sum) + delta);
`endif
    idle(int'(RSTP) + 10);
    chk({tag, "_nwr"}, 64'(wq.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      w = (i < wq.size()) ? wq[i] : wr_t'(0);
      chk({tag, "_addr"}, 64'(w.a), 64'(17'(base + 32'(i))));
      chk({tag, "_data"}, 64'(w.d), 64'(words[i]));
      chk({tag, "_wstrb"}, 64'(w.s), 64'(4'hF));
    end
    chk({tag, "_done"}, 64'(done_cnt - d0), ok ? 64'(1) : 64'(0));
    chk({tag, "_err"}, 64'(err_cnt - e0), ok ? 64'(0) : 64'(1));
    chk({tag, "_rstlen"}, 64'(rstlow_cnt - r0), ok ? 64'(RSTP) : 64'(0));
    chk({tag, "_sysrst"}, 64'(sys_rst_n), 64'(1));
    chk({tag, "_mode_end"}, 64'(prog_mode), 64'(0));
  endtask

  initial begin
    int e0;
    int d0;
    int r0;
    int lat;
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    core_addr = '0;
    core_data = '0;
    core_strb = '0;
    idle(3);
    chk("rst_mode", 64'(prog_mode), 64'(0));
    chk("rst_sysrst", 64'(sys_rst_n), 64'(1));
    chk("rst_done", 64'(prog_done), 64'(0));
    chk("rst_err", 64'(prog_err), 64'(0));
    rst_n = 1'b1;
    idle(2);

    // Idle passthrough of the core write port.
    core_addr = 17'($urandom);
    core_data = $urandom;
    core_strb = 4'h3;
    #2;
    chk("pt_addr", 64'(ram_addr), 64'(core_addr));
    chk("pt_data", 64'(ram_data), 64'(core_data));
    chk("pt_strb", 64'(ram_strb), 64'(4'h3));
    core_strb = 4'h0;
    idle(1);
    wq.delete();

    words = '{32'hDEADBEEF, 32'h01234567};
    do_load(32'h00000010, 8'h00, 1'b0, "basic");

    // Restart on the first magic character, random truncated base.
    send_str("TEK");
    words = '{$urandom, $urandom, $urandom};
    do_load($urandom, 8'h00, 1'b0, "restart");

    // Broken unlock: silently back to idle.
    e0 = err_cnt;
    wq.delete();
    send_str("TEKX");
    idle(20);
    chk("tekx_err", 64'(err_cnt - e0), 64'(0));
    chk("tekx_mode", 64'(prog_mode), 64'(0));
    chk("tekx_nwr", 64'(wq.size()), 64'(0));

    words = '{$urandom, $urandom};
    do_load(32'h0001FFFF, 8'h00, 1'b0, "wrap");

    words = '{$urandom, $urandom};
    do_load($urandom, 8'h00, 1'b1, "noise");

    words.delete();
    do_load($urandom, 8'h00, 1'b0, "cnt0");

    // Stall after two data bytes.
    e0 = err_cnt;
    d0 = done_cnt;
    r0 = rstlow_cnt;
    wq.delete();
    send_str("TEKNOFEST");
    send_w32($urandom);
    send_w32(32'd2);
    send_byte(8'($urandom));
    idle(2);
    send_byte(8'($urandom));
    lat = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (prog_err) begin
        lat = c;
        break;
      end
    end
    idle(5);
    chk("tmo_seen_lat", 64'(lat >= int'(TMO) && lat <= int'(TMO) + 2), 64'(1));
    chk("tmo_err", 64'(err_cnt - e0), 64'(1));
    chk("tmo_done", 64'(done_cnt - d0), 64'(0));
    chk("tmo_rst", 64'(rstlow_cnt - r0), 64'(0));
    chk("tmo_mode", 64'(prog_mode), 64'(0));
    chk("tmo_nwr", 64'(wq.size()), 64'(0));

    // Reset in the middle of the second word: first word stays written.
    d0 = done_cnt;
    wq.delete();
    send_str("TEKNOFEST");
    send_w32(32'h00000100);
    send_w32(32'd3);
    send_w32($urandom);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    rst_n = 1'b0;
    idle(2);
    chk("mrst_mode", 64'(prog_mode), 64'(0));
    chk("mrst_sysrst", 64'(sys_rst_n), 64'(1));
    rst_n = 1'b1;
    idle(5);
    chk("mrst_nwr", 64'(wq.size()), 64'(1));
    chk("mrst_done", 64'(done_cnt - d0), 64'(0));

`ifdef LOADER_CHECKSUM_EN
    words = '{32'h01020304};
    do_load($urandom, 8'h00, 1'b0, "csum_ok");
    words = '{32'h01020304};
    do_load($urandom, 8'h01, 1'b0, "csum_bad");
`endif

    words = '{$urandom};
    do_load($urandom, 8'h00, 1'b0, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
